// File: rtl/auth_pkg.sv
// -----------------------------------------------------------------------------
// auth_pkg
//   Shared types and width helpers for the auth_response_gate slice.
//   - auth_state_e : FSM states of the response gate
//   - fail_cnt_w   : width of the consecutive-failure counter for a given limit
//   - timer_w      : width of the shared down-timer. It must hold the larger of
//                    the two preload values (RESP_LATENCY-2 and LOCKOUT_CYCLES-1).
// -----------------------------------------------------------------------------
package auth_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        RESP    = 2'd2,
        LOCKOUT = 2'd3
    } auth_state_e;

    function automatic int fail_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int timer_w(input int resp_latency, input int lockout_cycles);
        int max_load;
        max_load = (resp_latency - 2 > lockout_cycles - 1) ? (resp_latency - 2)
                                                            : (lockout_cycles - 1);
        return (max_load < 1) ? 1 : $clog2(max_load + 1);
    endfunction

endpackage

// File: rtl/auth_down_timer.sv
// -----------------------------------------------------------------------------
// auth_down_timer
//   Loadable down-counter. It is shared by the HOLD (response latency) and
//   LOCKOUT phases of auth_response_gate. The counter saturates at zero.
//   Ports:
//     clk, rst    : clock and synchronous active-high reset
//     load        : load load_value this cycle (takes priority over counting)
//     load_value  : preload value
//     zero        : count is zero now (combinational)
//     zero_q      : count was zero at the previous edge and no load has
//                   occurred since. This gives one extra cycle of delay for
//                   users that need it.
// -----------------------------------------------------------------------------
module auth_down_timer #(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [TW-1:0] load_value,
    output logic          zero,
    output logic          zero_q
);

    logic [TW-1:0] count_reg;
    logic          zero_q_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg  <= '0;
            zero_q_reg <= 1'b0;
        end else if (load) begin
            count_reg  <= load_value;
            zero_q_reg <= 1'b0;
        end else begin
            if (count_reg != '0) begin
                count_reg <= count_reg - TW'(1);
            end
            zero_q_reg <= (count_reg == '0);
        end
    end

    assign zero   = (count_reg == '0);
    assign zero_q = zero_q_reg;

endmodule

// File: rtl/auth_response_gate.sv
// -----------------------------------------------------------------------------
// auth_response_gate
//   Downstream stage of the secret/input byte comparator. It accepts one compare
//   result at a time and returns grant/deny exactly RESP_LATENCY cycles after
//   acceptance. The latency is the same whatever the outcome. The block counts
//   consecutive failures and locks out new compares after MAX_FAILS failures.
//
//   Build option: define AUTH_PERMANENT_LOCK_EN to make lockout permanent. In
//   that build only rst leaves LOCKOUT, and LOCKOUT_CYCLES has no effect.
//
//   Ports:
//     clk, rst    : clock and synchronous active-high reset
//     cmp_valid   : comparator result valid
//     cmp_match   : comparator result, 1 = secret matched
//     cmp_ready   : block can accept a result (IDLE only)
//     resp_valid  : response available
//     resp_ready  : consumer accepts response
//     resp_grant  : access granted; 0 whenever resp_valid is 0
//     locked      : lockout window active
//     fail_count  : consecutive failure count
// -----------------------------------------------------------------------------
module auth_response_gate
    import auth_pkg::*;
#(
    parameter int RESP_LATENCY   = 16,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 256
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                cmp_valid,
    input  logic                                cmp_match,
    output logic                                cmp_ready,
    output logic                                resp_valid,
    input  logic                                resp_ready,
    output logic                                resp_grant,
    output logic                                locked,
    output logic [fail_cnt_w(MAX_FAILS)-1:0]    fail_count
);

    localparam int FCW = fail_cnt_w(MAX_FAILS);
    localparam int TW  = timer_w(RESP_LATENCY, LOCKOUT_CYCLES);

    auth_state_e    state_reg, state_next;
    logic           match_q_reg, match_q_next;
    logic [FCW-1:0] fail_count_reg, fail_count_next;
    logic [FCW-1:0] fail_inc;

    logic           timer_load;
    logic [TW-1:0]  timer_load_value;
    logic           timer_zero;
    logic           timer_zero_q;

    auth_down_timer #(
        .TW (TW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (timer_load_value),
        .zero       (timer_zero),
        .zero_q     (timer_zero_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            match_q_reg    <= 1'b0;
            fail_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            match_q_reg    <= match_q_next;
            fail_count_reg <= fail_count_next;
        end
    end

    // The failure counter saturates at MAX_FAILS.
    assign fail_inc = (fail_count_reg == FCW'(MAX_FAILS)) ? fail_count_reg
                                                           : fail_count_reg + FCW'(1);

    always_comb begin
        state_next       = state_reg;
        match_q_next     = match_q_reg;
        fail_count_next  = fail_count_reg;
        timer_load       = 1'b0;
        timer_load_value = '0;

        unique case (state_reg)
            IDLE: begin
                if (cmp_valid) begin
                    match_q_next     = cmp_match;
                    timer_load       = 1'b1;
                    timer_load_value = TW'(RESP_LATENCY - 2);
                    state_next       = HOLD;
                end
            end
            // Preloading RESP_LATENCY-2 and leaving on the delayed zero flag
            // puts resp_valid exactly RESP_LATENCY edges after acceptance.
            // Both outcomes take this same path.
            HOLD: begin
                if (timer_zero_q) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    if (match_q_reg) begin
                        fail_count_next = '0;
                        state_next      = IDLE;
                    end else begin
                        fail_count_next = fail_inc;
                        if (fail_inc == FCW'(MAX_FAILS)) begin
                            timer_load       = 1'b1;
                            timer_load_value = TW'(LOCKOUT_CYCLES - 1);
                            state_next       = LOCKOUT;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
            end
            LOCKOUT: begin
`ifdef AUTH_PERMANENT_LOCK_EN
                // Lockout never expires; only rst leaves this state.
                state_next = LOCKOUT;
`else
                if (timer_zero) begin
                    fail_count_next = '0;
                    state_next      = IDLE;
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    assign cmp_ready  = (state_reg == IDLE);
    assign resp_valid = (state_reg == RESP);
    assign resp_grant = (state_reg == RESP) && match_q_reg;
    assign locked     = (state_reg == LOCKOUT);
    assign fail_count = fail_count_reg;

endmodule

// File: tb/tb_auth_response_gate.sv
// -----------------------------------------------------------------------------
// tb_auth_response_gate
//   Self-checking bench for auth_response_gate with default parameters.
//   The reference model works at the transaction level. It keeps the
//   acceptance timestamp, the pending outcome, the failure count and the
//   lockout expiry time, and derives the expected outputs after every edge.
//   A directed phase runs first, followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_auth_response_gate;

    localparam int L  = 16;
    localparam int MF = 3;
    localparam int LC = 256;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmp_valid = 1'b0;
    logic       cmp_match = 1'b0;
    logic       cmp_ready;
    logic       resp_valid;
    logic       resp_ready = 1'b0;
    logic       resp_grant;
    logic       locked;
    logic [1:0] fail_count;

    auth_response_gate dut (
        .clk        (clk),
        .rst        (rst),
        .cmp_valid  (cmp_valid),
        .cmp_match  (cmp_match),
        .cmp_ready  (cmp_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_grant (resp_grant),
        .locked     (locked),
        .fail_count (fail_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transaction-level reference model
    int edge_n     = 0;
    bit m_busy     = 1'b0;
    bit m_pm       = 1'b0;
    bit m_locked   = 1'b0;
    int m_acc      = 0;
    int m_lock_end = 0;
    int m_fails    = 0;

    task automatic model_edge(input bit v, input bit m, input bit r, input bit rs);
        if (rs) begin
            m_busy   = 1'b0;
            m_pm     = 1'b0;
            m_locked = 1'b0;
            m_fails  = 0;
        end else if (m_locked) begin
            if (edge_n == m_lock_end) begin
                m_locked = 1'b0;
                m_fails  = 0;
            end
        end else if (!m_busy) begin
            if (v) begin
                m_busy = 1'b1;
                m_acc  = edge_n;
                m_pm   = m;
            end
        end else if ((edge_n - 1 >= m_acc + L) && r) begin
            m_busy = 1'b0;
            if (m_pm) begin
                m_fails = 0;
            end else begin
                m_fails = (m_fails < MF) ? m_fails + 1 : MF;
                if (m_fails == MF) begin
                    m_locked = 1'b1;
`ifdef AUTH_PERMANENT_LOCK_EN
                    m_lock_end = 32'h7fff_ffff;
`else
                    m_lock_end = edge_n + LC;
`endif
                end
            end
        end
    endtask

    task automatic step(input bit v, input bit m, input bit r, input bit rs);
        bit e_ready, e_rvalid, e_grant;
        cmp_valid  = v;
        cmp_match  = m;
        resp_ready = r;
        rst        = rs;
        @(posedge clk);
        #1;
        edge_n++;
        model_edge(v, m, r, rs);
        e_ready  = !m_locked && !m_busy;
        e_rvalid = !m_locked && m_busy && (edge_n >= m_acc + L);
        e_grant  = e_rvalid && m_pm;
        check_eq("ctrl{ready,rvalid,grant,locked}",
                 {28'd0, cmp_ready, resp_valid, resp_grant, locked},
                 {28'd0, e_ready, e_rvalid, e_grant, m_locked});
        check_eq("fail_count", {30'd0, fail_count}, m_fails);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!cmp_ready && n < 2000) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            n++;
        end
        check_eq("idle_timeout", {31'd0, cmp_ready}, 32'd1);
    endtask

    // Accept one result, measure the latency, hold in RESP, then hand shake.
    task automatic directed_resp(input bit m, input int hold_cycles);
        int lat;
        wait_idle();
        step(1'b1, m, 1'b0, 1'b0);
        lat = 0;
        while (!resp_valid && lat < 50) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            lat++;
        end
        check_eq("latency", lat, L);
        check_eq("grant", {31'd0, resp_grant}, {31'd0, m});
        for (int i = 0; i < hold_cycles; i++) begin
            step($urandom_range(0, 1) != 0, 1'b1, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        int lock_len;

        // Reset and check the reset state
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check_eq("reset_state", {28'd0, cmp_ready, resp_valid, resp_grant, locked}, 32'h8);
        check_eq("reset_fc", {30'd0, fail_count}, 32'd0);

        // Match and mismatch responses both take the same latency
        directed_resp(1'b1, 0);
        check_eq("fc_after_match", {30'd0, fail_count}, 32'd0);
        directed_resp(1'b0, 5);
        check_eq("fc_after_miss", {30'd0, fail_count}, 32'd1);

        // Two mismatches, then a match: the count clears and no lockout occurs
        directed_resp(1'b0, 0);
        check_eq("fc_two", {30'd0, fail_count}, 32'd2);
        directed_resp(1'b1, 2);
        check_eq("fc_cleared", {30'd0, fail_count}, 32'd0);
        check_eq("no_lock", {31'd0, locked}, 32'd0);

        // Three mismatches lead to lockout; cmp_valid pulses are ignored meanwhile
        directed_resp(1'b0, 0);
        directed_resp(1'b0, 0);
        directed_resp(1'b0, 0);
        check_eq("lock_entry", {31'd0, locked}, 32'd1);
        lock_len = 0;
        while (locked && lock_len < 1100) begin
            step($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, 1'b1, 1'b0);
            lock_len++;
        end
`ifdef AUTH_PERMANENT_LOCK_EN
        check_eq("lock_len", lock_len, 1100);
        step(1'b0, 1'b0, 1'b0, 1'b1);
`else
        check_eq("lock_len", lock_len, LC);
`endif
        check_eq("post_lock", {28'd0, cmp_ready, resp_valid, resp_grant, locked}, 32'h8);

        // Reset in the middle of HOLD
        wait_idle();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("rst_mid_hold", {28'd0, cmp_ready, resp_valid, resp_grant, locked}, 32'h8);

        // Reset in the middle of LOCKOUT
        for (int k = 0; k < 3; k++) directed_resp(1'b0, 0);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("rst_mid_lock", {28'd0, cmp_ready, resp_valid, resp_grant, locked}, 32'h8);
        check_eq("rst_mid_lock_fc", {30'd0, fail_count}, 32'd0);

        // Randomized traffic checked against the model on every cycle
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 1) != 0,
                 $urandom_range(0, 9) < 3,
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 499) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
